add_delay_pipe: RTL and testbench
=================================

Name: add_delay_pipe

Overview:
- Clocked successor to the combinational adder with a 5 ns RHS delay: fixed-latency add/subtract pipeline.
- Operand widths and latency are parameters; a valid/ready handshake supports backpressure.
- Sits between operand producers and result consumers. It replaces the transport-delay modelling with a cycle-accurate, synthesizable delay line.

Parameters:
- WIDTH, 4, operand width in bits; result is WIDTH+1 bits.
- LATENCY, 5, cycles from accepted input to result presented; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b/sub is valid this cycle.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  sum is valid.
- out_ready  input  1  consumer takes sum this cycle.
- sum  output  WIDTH+1  result.
- count  output  $clog2(LATENCY+1)  number of valid entries in the pipe.

Behaviour:
- Reset (rst=1 at a clk edge): clears every stage valid bit and every stage data register to 0.
  - After reset: out_valid=0, sum=0, count=0, in_ready=1.
  - Reset mid-operation discards all in-flight results; nothing emerges afterwards.
- Pipe structure: LATENCY stages; stage 1 registers the arithmetic result, stages 2..LATENCY shift it.
  - The output ports are driven directly by stage LATENCY.
  - There is no combinational path from a/b to sum.
- Stall: stall = out_valid & ~out_ready.
  - While stall=1, every stage holds its contents (global stall, no bubble collapsing).
- in_ready = ~stall, combinational from out_valid/out_ready.
- Accept: in_valid & in_ready at an edge loads stage 1 with valid=1.
- Bubble: in_ready=1 and in_valid=0 loads stage 1 with valid=0. Data in that stage is don't-care; keep it at its previous value.
- Latency: with no stalls, a pair accepted at edge N appears with out_valid=1 after edge N+LATENCY-1.
  - It is therefore visible LATENCY cycles after being presented.
  - Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle when out_ready is held high.
- Arithmetic, WIDTH+1 bits, modulo 2^(WIDTH+1):
  - sub=0: sum = {0,a} + {0,b}; MSB is the carry.
  - sub=1: sum = {0,a} - {0,b}; MSB=1 indicates borrow (a<b).
- sub is sampled together with a/b at acceptance. Changing it later does not affect in-flight entries.
- count: population count of the stage valid bits, registered alongside the pipe.
  - It increments on accept without retire, decrements on retire (out_valid & out_ready) without accept, and is unchanged when both or neither occur.
  - It never exceeds LATENCY.
- Simultaneous accept and retire in the same cycle is legal and is the normal streaming case.
- Full pipe with out_ready=0: in_ready=0 and count stays at LATENCY; in_valid is ignored.
- Operands outside handshake (in_valid=0) never alter sum or out_valid.
- LATENCY=1: stage 1 is the output stage; the stall/accept rules are unchanged.

Decomposition:
- Shared package add_delay_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1;
  - the LATENCY_MAX=32 constant;
  - a count-width function wrapping $clog2(LATENCY+1).
- One natural sub-module: add_pipe_stage, a WIDTH+1 data register plus valid bit with hold (stall) input and synchronous reset.
  - It is instantiated LATENCY-1 times in a generate loop.
  - Stage 1, containing the arithmetic, stays in the top.

Test Plan:
- Basic add (WIDTH=4, LATENCY=5, out_ready=1): a=0xE, b=0x3, sub=0 presented one cycle, accepted at edge N -> out_valid=1 with sum=0x11 after edge N+4 for exactly one cycle; count goes 1..1 then 0.
- Back-to-back stream: pairs (0xA,0x0), (0xE,0x3), (0xF,0x3), (0xF,0x1) on consecutive cycles -> sums 0x0A, 0x11, 0x12, 0x10 on consecutive cycles, in order; count peaks at 4.
- Subtract/borrow: a=0x2, b=0x8, sub=1 -> sum=0x1A (MSB=1); a=0x8, b=0x2, sub=1 -> sum=0x06.
- Backpressure: stream 7 pairs with out_ready=0 from the first result onward -> pipe fills, count=5, in_ready=0, sixth/seventh pairs are not accepted until out_ready=1; then results drain in order with none lost or duplicated.
- Reset mid-flight: accept 3 pairs, assert rst for one edge -> out_valid=0, sum=0, count=0, in_ready=1 next cycle; no result from the discarded pairs ever appears.
- LATENCY=1, WIDTH=8: a=0xFF, b=0x01 -> sum=0x100 one edge after acceptance; sub=1, a=0x00, b=0x01 -> sum=0x1FF.

Source files
------------

// File: rtl/add_delay_pkg.sv
// Shared constants and helpers for the add/subtract delay pipeline.
package add_delay_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned LATENCY_MAX = 32;

    // Width of a counter that can hold 0..latency.
    function automatic int unsigned count_width(input int unsigned latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One shift stage of the delay line: data plus valid bit, frozen while hold is high.
module add_pipe_stage #(
    parameter int unsigned DW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!hold) begin
            valid <= in_valid;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/add_delay_pipe.sv
// Fixed-latency add/subtract pipeline with valid/ready handshake and global stall.
module add_delay_pipe
    import add_delay_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                sub,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH:0]                      sum,
    output logic [count_width(LATENCY)-1:0]     count
);

    localparam int unsigned DW = WIDTH + 1;
    localparam int unsigned CW = count_width(LATENCY);

    logic          stall;
    logic          accept;
    logic          retire;
    logic [DW-1:0] result;
    logic          v1;
    logic [DW-1:0] d1;
    logic          vld [1:LATENCY];
    logic [DW-1:0] dat [1:LATENCY];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign retire   = out_valid & out_ready;

    assign result = (sub == OP_SUB) ? ({1'b0, a} - {1'b0, b})
                                    : ({1'b0, a} + {1'b0, b});

    // Stage 1 holds the arithmetic; bubbles keep the previous data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (!stall) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= result;
            end
        end
    end

    assign vld[1] = v1;
    assign dat[1] = d1;

    for (genvar i = 2; i <= LATENCY; i++) begin : g_stage
        add_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .hold     (stall),
            .in_valid (vld[i-1]),
            .in_data  (dat[i-1]),
            .valid    (vld[i]),
            .data     (dat[i])
        );
    end

    assign out_valid = vld[LATENCY];
    assign sum       = dat[LATENCY];

    // Occupancy tracks accepts and retires so it equals the number of live stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (accept && !retire) begin
            count <= count + CW'(1);
        end else if (retire && !accept) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_add_delay_pipe.sv
// Bench for add_delay_pipe: queue-based reference model plus directed literal checks.
module tb_add_delay_pipe;
    import add_delay_pkg::*;

    localparam int unsigned W5 = 4;
    localparam int unsigned L5 = 5;
    localparam int unsigned W1 = 8;
    localparam int unsigned L1 = 1;

    logic clk = 1'b0;
    logic rst;

    logic                         iv5, ir5, sb5, ov5, or5;
    logic [W5-1:0]                a5, b5;
    logic [W5:0]                  s5;
    logic [count_width(L5)-1:0]   c5;

    logic                         iv1, ir1, sb1, ov1, or1;
    logic [W1-1:0]                a1, b1;
    logic [W1:0]                  s1;
    logic [count_width(L1)-1:0]   c1;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_on = 1'b0;
    bit h5, h1;

    typedef struct {
        int unsigned val;
        int unsigned pos;
    } ent_t;

    ent_t        q5[$];
    ent_t        q1[$];
    logic [W5:0] log5[$];

    int unsigned st_exp [4] = '{32'h0A, 32'h11, 32'h12, 32'h10};
    int unsigned bp_exp [7] = '{32'h03, 32'h07, 32'h0B, 32'h0F, 32'h13, 32'h17, 32'h1B};

    always #5 clk = ~clk;

    add_delay_pipe #(.WIDTH(W5), .LATENCY(L5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .a(a5), .b(b5), .sub(sb5),
        .out_valid(ov5), .out_ready(or5), .sum(s5), .count(c5)
    );

    add_delay_pipe #(.WIDTH(W1), .LATENCY(L1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sb1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .count(c1)
    );

    function automatic int unsigned ref_sum(input int unsigned x, input int unsigned y,
                                            input logic s, input int unsigned w);
        int unsigned m;
        m = 32'd1 << (w + 1);
        return (s == OP_SUB) ? ((x + m - y) % m) : ((x + y) % m);
    endfunction

    function automatic logic ov_exp5();
        return (q5.size() > 0) && (q5[0].pos == L5);
    endfunction

    function automatic logic ov_exp1();
        return (q1.size() > 0) && (q1[0].pos == L1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each accepted pair travels as an entry that advances one stage per unstalled edge.
    always @(posedge clk) begin
        if (rst) begin
            q5.delete();
            q1.delete();
        end else begin
            h5 = ov_exp5();
            if (!(h5 && !or5)) begin
                if (h5) void'(q5.pop_front());
                foreach (q5[i]) q5[i].pos = q5[i].pos + 1;
                if (iv5) q5.push_back('{val: ref_sum(32'(a5), 32'(b5), sb5, W5), pos: 1});
            end
            h1 = ov_exp1();
            if (!(h1 && !or1)) begin
                if (h1) void'(q1.pop_front());
                foreach (q1[i]) q1[i].pos = q1[i].pos + 1;
                if (iv1) q1.push_back('{val: ref_sum(32'(a1), 32'(b1), sb1, W1), pos: 1});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_ov5", 32'(ov5), 32'(ov_exp5()));
            if (ov_exp5()) chk("m_sum5", 32'(s5), q5[0].val);
            chk("m_cnt5", 32'(c5), 32'(q5.size()));
            chk("m_rdy5", 32'(ir5), 32'(!(ov_exp5() && !or5)));
            chk("m_ov1", 32'(ov1), 32'(ov_exp1()));
            if (ov_exp1()) chk("m_sum1", 32'(s1), q1[0].val);
            chk("m_cnt1", 32'(c1), 32'(q1.size()));
            chk("m_rdy1", 32'(ir1), 32'(!(ov_exp1() && !or1)));
        end
        if (ov5 && or5 && !rst) log5.push_back(s5);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send5(input logic [W5-1:0] x, input logic [W5-1:0] y, input logic s);
        logic acc;
        iv5 = 1'b1; a5 = x; b5 = y; sb5 = s;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = ir5;
            tick();
        end
        iv5 = 1'b0;
        chk("send5_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_log5(input int n);
        for (int k = 0; k < 100 && log5.size() < n; k++) tick();
        chk("drain_count", 32'(log5.size()), 32'(n));
    endtask

    initial begin
        rst = 1'b1;
        iv5 = 1'b0; a5 = '0; b5 = '0; sb5 = OP_ADD; or5 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; sb1 = OP_ADD; or1 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_on = 1'b1;

        @(negedge clk);
        chk("rst_ov5", 32'(ov5), 32'd0);
        chk("rst_sum5", 32'(s5), 32'd0);
        chk("rst_cnt5", 32'(c5), 32'd0);
        chk("rst_rdy5", 32'(ir5), 32'd1);
        chk("rst_ov1", 32'(ov1), 32'd0);
        chk("rst_sum1", 32'(s1), 32'd0);
        chk("rst_cnt1", 32'(c1), 32'd0);
        chk("rst_rdy1", 32'(ir1), 32'd1);
        tick();

        // Single add: visible after edge N+4 for exactly one cycle.
        iv5 = 1'b1; a5 = 4'hE; b5 = 4'h3; sb5 = OP_ADD;
        tick();
        iv5 = 1'b0;
        @(negedge clk);
        chk("basic_cnt_n", 32'(c5), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("basic_ov_n3", 32'(ov5), 32'd0);
        tick();
        @(negedge clk);
        chk("basic_ov_n4", 32'(ov5), 32'd1);
        chk("basic_sum", 32'(s5), 32'h11);
        chk("basic_cnt_n4", 32'(c5), 32'd1);
        tick();
        @(negedge clk);
        chk("basic_ov_n5", 32'(ov5), 32'd0);
        chk("basic_cnt_n5", 32'(c5), 32'd0);
        tick();

        // Back-to-back stream.
        log5.delete();
        send5(4'hA, 4'h0, OP_ADD);
        send5(4'hE, 4'h3, OP_ADD);
        send5(4'hF, 4'h3, OP_ADD);
        send5(4'hF, 4'h1, OP_ADD);
        @(negedge clk);
        chk("stream_cnt_peak", 32'(c5), 32'd4);
        tick();
        wait_log5(4);
        for (int i = 0; i < 4 && i < log5.size(); i++) chk("stream_sum", 32'(log5[i]), st_exp[i]);

        // Subtract with and without borrow.
        log5.delete();
        send5(4'h2, 4'h8, OP_SUB);
        send5(4'h8, 4'h2, OP_SUB);
        wait_log5(2);
        if (log5.size() >= 2) begin
            chk("sub_borrow", 32'(log5[0]), 32'h1A);
            chk("sub_plain", 32'(log5[1]), 32'h06);
        end
        repeat (6) tick();

        // Backpressure: fill, refuse, then drain in order.
        log5.delete();
        or5 = 1'b0;
        for (int i = 0; i < 5; i++) send5(4'(2 * i + 1), 4'(2 * i + 2), OP_ADD);
        @(negedge clk);
        chk("bp_cnt_full", 32'(c5), 32'd5);
        chk("bp_rdy_full", 32'(ir5), 32'd0);
        chk("bp_ov_full", 32'(ov5), 32'd1);
        tick();
        iv5 = 1'b1; a5 = 4'd11; b5 = 4'd12; sb5 = OP_ADD;
        repeat (3) begin
            @(negedge clk);
            chk("bp_cnt_hold", 32'(c5), 32'd5);
            chk("bp_rdy_hold", 32'(ir5), 32'd0);
            tick();
        end
        chk("bp_no_retire", 32'(log5.size()), 32'd0);
        or5 = 1'b1;
        send5(4'd11, 4'd12, OP_ADD);
        send5(4'd13, 4'd14, OP_ADD);
        wait_log5(7);
        for (int i = 0; i < 7 && i < log5.size(); i++) chk("bp_sum", 32'(log5[i]), bp_exp[i]);
        repeat (8) tick();
        chk("bp_no_dup", 32'(log5.size()), 32'd7);

        // Reset discards in-flight entries.
        log5.delete();
        send5(4'h1, 4'h1, OP_ADD);
        send5(4'h2, 4'h2, OP_ADD);
        send5(4'h3, 4'h3, OP_ADD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ov", 32'(ov5), 32'd0);
        chk("mrst_sum", 32'(s5), 32'd0);
        chk("mrst_cnt", 32'(c5), 32'd0);
        chk("mrst_rdy", 32'(ir5), 32'd1);
        repeat (12) tick();
        chk("mrst_nothing_out", 32'(log5.size()), 32'd0);

        // Single-stage instance.
        iv1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; sb1 = OP_ADD;
        tick();
        iv1 = 1'b0;
        @(negedge clk);
        chk("l1_ov", 32'(ov1), 32'd1);
        chk("l1_carry", 32'(s1), 32'h100);
        chk("l1_cnt", 32'(c1), 32'd1);
        tick();
        iv1 = 1'b1; a1 = 8'h00; b1 = 8'h01; sb1 = OP_SUB;
        tick();
        iv1 = 1'b0;
        @(negedge clk);
        chk("l1_borrow", 32'(s1), 32'h1FF);
        tick();

        // Randomized traffic with random backpressure and rare resets.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            iv5 = 1'($urandom_range(0, 1));
            a5  = W5'($urandom);
            b5  = W5'($urandom);
            sb5 = 1'($urandom_range(0, 1));
            or5 = ($urandom_range(0, 3) != 0);
            iv1 = 1'($urandom_range(0, 1));
            a1  = W1'($urandom);
            b1  = W1'($urandom);
            sb1 = 1'($urandom_range(0, 1));
            or1 = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        iv5 = 1'b0; or5 = 1'b1;
        iv1 = 1'b0; or1 = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
